fios_res_collector: RTL and testbench

Word-serial result reader for the FIOS Montgomery multiplier. It captures the 17-bit result words streamed from the multiplier's result output, least significant word first. While the words arrive, it performs the final conditional subtraction of the modulus. It then presents the fully reduced s×17-bit result through a valid/ready handshake to the downstream consumer. It sits directly after the multiplier array and its sequencer.

---
 rtl/fios_pkg.sv | 15 +
 rtl/word_sub_17.sv | 18 +
 rtl/fios_res_collector.sv | 145 ++++++++++++++
 tb/tb_fios_res_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// Shared types and constants for the FIOS Montgomery multiplier result path.
package fios_pkg;

    localparam int WORD_W = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } coll_state_e;

    // Bit WORD_W of a word subtraction is the borrow out
    typedef logic [WORD_W:0] sub_res_t;

endpackage

// File: rtl/word_sub_17.sv
// Combinational 17-bit subtract-with-borrow cell: {bout, d} = a - b - bin.
module word_sub_17
    import fios_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              bin,
    output logic [WORD_W-1:0] d,
    output logic              bout
);

    sub_res_t t_s;

    assign t_s  = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};
    assign d    = t_s[WORD_W-1:0];
    assign bout = t_s[WORD_W];

endmodule

// File: rtl/fios_res_collector.sv
// Captures LSW-first result words, subtracts the modulus on the fly and
// presents the reduced s-word result through a valid/ready handshake.
module fios_res_collector
    import fios_pkg::*;
#(
    parameter int s = 8
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic                res_valid_i,
    input  logic [WORD_W-1:0]   res_i,
    input  logic [s*WORD_W-1:0] p_i,
    output logic [s*WORD_W-1:0] res_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int              CNT_W    = (s > 1) ? $clog2(s) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(s - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    coll_state_e           state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  borrow_r;
    logic                  sel_r;
    logic                  err_r;
    logic                  res_valid_r;
    logic                  busy_r;
    logic [s*WORD_W-1:0]   raw_r;
    logic [s*WORD_W-1:0]   diff_r;

    logic                  restart_s;
    logic [CNT_W-1:0]      idx_s;
    logic                  bin_s;
    logic [WORD_W-1:0]     p_word_s;
    logic [WORD_W-1:0]     d_s;
    logic                  bout_s;
    logic [s*WORD_W-1:0]   raw_nxt_s;
    logic [s*WORD_W-1:0]   diff_nxt_s;

    // A start inside COLLECT makes a coincident word become word 0 with no borrow
    assign restart_s = (state_r == COLLECT) && start_i;
    assign idx_s     = ((state_r == COLLECT) && !restart_s) ? cnt_r : '0;
    assign bin_s     = ((state_r == COLLECT) && !restart_s) ? borrow_r : 1'b0;
    assign p_word_s  = p_i[idx_s*WORD_W +: WORD_W];

    word_sub_17 u_sub (
        .a    (res_i),
        .b    (p_word_s),
        .bin  (bin_s),
        .d    (d_s),
        .bout (bout_s)
    );

    // Word arrays with the incoming word merged at its slot
    always_comb begin
        raw_nxt_s  = raw_r;
        diff_nxt_s = diff_r;
        for (int i = 0; i < s; i++) begin
            raw_nxt_s[i*WORD_W +: WORD_W]  = (idx_s == CNT_W'(i)) ? res_i : raw_r[i*WORD_W +: WORD_W];
            diff_nxt_s[i*WORD_W +: WORD_W] = (idx_s == CNT_W'(i)) ? d_s   : diff_r[i*WORD_W +: WORD_W];
        end
    end

    // Collector state machine, word capture and registered status outputs
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            borrow_r    <= 1'b0;
            sel_r       <= 1'b0;
            err_r       <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            raw_r       <= '0;
            diff_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (res_valid_i) begin
                        err_r <= 1'b1;
                    end
                    if (start_i) begin
                        state_r  <= COLLECT;
                        cnt_r    <= '0;
                        borrow_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (res_valid_i) begin
                        raw_r  <= raw_nxt_s;
                        diff_r <= diff_nxt_s;
                        if (idx_s == LAST_IDX) begin
                            state_r     <= HOLD;
                            cnt_r       <= '0;
                            borrow_r    <= bout_s;
                            sel_r       <= ~bout_s;
                            res_valid_r <= 1'b1;
                        end else begin
                            cnt_r    <= idx_s + CNT_ONE;
                            borrow_r <= bout_s;
                        end
                    end else if (start_i) begin
                        cnt_r    <= '0;
                        borrow_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (res_valid_i) begin
                        err_r <= 1'b1;
                    end
                    if (res_ready_i) begin
                        res_valid_r <= 1'b0;
                        if (start_i) begin
                            state_r  <= COLLECT;
                            cnt_r    <= '0;
                            borrow_r <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (start_i) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Both candidates are registered, so this select only moves on clock edges
    assign res_o       = sel_r ? diff_r : raw_r;
    assign res_valid_o = res_valid_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector with s=2 and p = 2^17+5.
module tb_fios_res_collector;

    localparam int S = 2;
    localparam int W = 17;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             res_valid;
    logic [W-1:0]     res_w;
    logic [S*W-1:0]   p;
    logic [S*W-1:0]   res_out;
    logic             res_valid_out;
    logic             ready;
    logic             busy;
    logic             err;

    logic [S*W-1:0]   exp_q[$];
    int               pass_cnt = 0;
    int               total_cnt = 0;

    fios_res_collector #(.s(S)) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .start_i     (start),
        .res_valid_i (res_valid),
        .res_i       (res_w),
        .p_i         (p),
        .res_o       (res_out),
        .res_valid_o (res_valid_out),
        .res_ready_i (ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start pulse, then two back-to-back words; returns at the negedge after word 1 is captured
    task automatic send_result(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [S*W-1:0] expv);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        res_valid = 1'b1;
        res_w     = w0;
        exp_q.push_back(expv);
        @(negedge clk);
        res_w = w1;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++; if (res_out !== '0) $display("FAIL reset_res_o: got %h want 0", res_out); else pass_cnt++;
        total_cnt++; if (res_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_value(input string name, input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [S*W-1:0] expv);
        logic [S*W-1:0] e;
        send_result(w0, w1, expv);
        total_cnt++;
        if (res_valid_out !== 1'b1) $display("FAIL %s_latency: res_valid_o got %b want 1", name, res_valid_out);
        else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (res_out !== e) $display("FAIL %s_res_o: got %h want %h", name, res_out, e);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s_busy_hold: got %b want 1", name, busy);
        else pass_cnt++;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        total_cnt++;
        if (res_valid_out !== 1'b0) $display("FAIL %s_valid_drop: got %b want 0", name, res_valid_out);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_busy_drop: got %b want 0", name, busy);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL %s_err: got %b want 0", name, err);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [S*W-1:0] e;
        bit ok;
        send_result(17'h00003, 17'h00001, {17'h00001, 17'h00003});
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (res_valid_out !== 1'b1 || res_out !== e)
                $display("FAIL bp_hold%0d: valid %b res_o %h want 1 %h", i, res_valid_out, res_out, e);
            else pass_cnt++;
            res_valid = (i == 2);
            res_w     = 17'h1ABCD;
            @(negedge clk);
        end
        res_valid = 1'b0;
        total_cnt++;
        if (res_out !== e) $display("FAIL bp_stable: got %h want %h", res_out, e); else pass_cnt++;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL bp_err: got %b want 1", err); else pass_cnt++;
        // Accept and restart in the same cycle
        ready = 1'b1;
        start = 1'b1;
        exp_q.push_back({17'h00000, 17'h00002});
        @(negedge clk);
        ready     = 1'b0;
        start     = 1'b0;
        res_valid = 1'b1;
        res_w     = 17'h00007;
        total_cnt++;
        if (busy !== 1'b1 || res_valid_out !== 1'b0)
            $display("FAIL b2b_handover: busy %b valid %b want 1 0", busy, res_valid_out);
        else pass_cnt++;
        @(negedge clk);
        res_w = 17'h00001;
        @(negedge clk);
        res_valid = 1'b0;
        wait_valid(ok);
        total_cnt++;
        if (!ok) $display("FAIL b2b_valid: timeout got 0 want 1"); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (res_out !== e) $display("FAIL b2b_res_o: got %h want %h", res_out, e); else pass_cnt++;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [S*W-1:0] e;
        bit ok;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        res_valid = 1'b1;
        res_w     = 17'h00007;
        @(negedge clk);
        res_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (res_out !== '0 || res_valid_out !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL mid_reset: res_o %h valid %b busy %b err %b want all 0",
                     res_out, res_valid_out, busy, err);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        send_result(17'h00007, 17'h00001, {17'h00000, 17'h00002});
        wait_valid(ok);
        total_cnt++;
        if (!ok) $display("FAIL mid_after_valid: timeout got 0 want 1"); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (res_out !== e) $display("FAIL mid_after_res_o: got %h want %h", res_out, e); else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL mid_after_err: got %b want 0", err); else pass_cnt++;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        res_valid = 1'b0;
        res_w     = '0;
        ready     = 1'b0;
        p         = {17'h00001, 17'h00005};
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_value("below_p", 17'h00003, 17'h00001, {17'h00001, 17'h00003});
        test_value("above_p", 17'h00007, 17'h00001, {17'h00000, 17'h00002});
        test_value("borrow",  17'h00002, 17'h00002, {17'h00000, 17'h1FFFD});
        test_value("equal_p", 17'h00005, 17'h00001, {17'h00000, 17'h00000});
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
